// File: rtl/regfile_pkg.sv
// Shared types, parameter defaults and the byte-merge helper for register_file_mp.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int RD_PORTS_DEF = 2;
    localparam int ZERO_REG_DEF = 1;
    // Widest entry the merge helper supports; callers cast to and from this width.
    localparam int MERGE_W      = 256;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_d,
        input logic [MERGE_W-1:0]   new_d,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_d;
        for (int i = 0; i < MERGE_W/8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_d[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register masking and, with REGFILE_BYPASS_EN, write bypass.
module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_mem_data,
`ifdef REGFILE_BYPASS_EN
    input  logic              i_wr_hit,
    input  logic [DATA_W-1:0] i_wr_data,
`endif
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    logic [DATA_W-1:0] w_data;

    // Select the value a read returns this cycle.
    always_comb begin
        w_data = i_mem_data;
`ifdef REGFILE_BYPASS_EN
        if (i_wr_hit) begin
            w_data = i_wr_data;
        end else begin
            w_data = i_mem_data;
        end
`endif
        if ((ZERO_REG != 0) && (i_raddr == {ADDR_W{1'b0}})) begin
            w_data = {DATA_W{1'b0}};
        end else begin
            w_data = w_data;
        end
    end

    // Register read data and the one-cycle valid pulse; data holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rdata  <= {DATA_W{1'b0}};
            o_rvalid <= 1'b0;
        end else if (i_rd) begin
            o_rdata  <= w_data;
            o_rvalid <= 1'b1;
        end else begin
            o_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enabled writes and a hardware clear sequencer.
// Optional same-cycle write-to-read bypass is built when REGFILE_BYPASS_EN is defined.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_PORTS = RD_PORTS_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sel,
    input  logic                       clear,
    input  logic                       wr,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wbe,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0] raddr,
    output logic [RD_PORTS*DATA_W-1:0] rdata,
    output logic [RD_PORTS-1:0]        rvalid,
    output logic                       busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_merged;

    assign busy     = r_busy;
    // Clear wins over a coincident write; entry 0 is never written when hard-wired to zero.
    assign w_wr_en  = sel && wr && !r_busy && !clear &&
                      !((ZERO_REG != 0) && (waddr == {ADDR_W{1'b0}}));
    assign w_merged = DATA_W'(byte_merge(MERGE_W'(r_mem[waddr]), MERGE_W'(wdata),
                                         (MERGE_W/8)'(wbe)));

    // Clear sequencer: walks every entry once after reset or on a clear request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CLEAR;
            r_ptr   <= {ADDR_W{1'b0}};
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
                IDLE: begin
                    if (clear) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_ptr <= {ADDR_W{1'b0}};
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= {ADDR_W{1'b0}};
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array; deliberately unreset, initialised only by the sequencer.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_ptr] <= {DATA_W{1'b0}};
        end else if (w_wr_en) begin
            r_mem[waddr] <= w_merged;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        assign w_raddr = raddr[p*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .reset      (reset),
            .i_rd       (sel && rd_en[p] && !r_busy),
            .i_raddr    (w_raddr),
            .i_mem_data (r_mem[w_raddr]),
`ifdef REGFILE_BYPASS_EN
            .i_wr_hit   (w_wr_en && (waddr == w_raddr)),
            .i_wr_data  (w_merged),
`endif
            .o_rdata    (rdata[p*DATA_W +: DATA_W]),
            .o_rvalid   (rvalid[p])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (default parameters), with a word-array reference model.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        clear;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [1:0]  rd_en;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [32];
    logic [31:0] exp_rd [2];

    register_file_mp dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .clear  (clear),
        .wr     (wr),
        .waddr  (waddr),
        .wdata  (wdata),
        .wbe    (wbe),
        .rd_en  (rd_en),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d,
                                        input logic [3:0] be);
        if (a != 5'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        sel = 1'b1; wr = 1'b1; waddr = a; wdata = d; wbe = be;
        cyc();
        wr = 1'b0;
        model_write(a, d, be);
    endtask

    task automatic read2(input string tag, input logic [4:0] a0, input logic [4:0] a1);
        sel = 1'b1; rd_en = 2'b11; raddr = {a1, a0};
        cyc();
        rd_en = 2'b00;
        exp_rd[0] = ref_rd(a0);
        exp_rd[1] = ref_rd(a1);
        chk({tag, "_valid"}, 64'(rvalid), 64'(2'b11));
        chk({tag, "_data"}, rdata, {exp_rd[1], exp_rd[0]});
    endtask

    // Counts cycles with busy high from now on; bounded so a stuck busy still ends the run.
    task automatic count_busy(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        chk(tag, 64'(n), 64'd32);
    endtask

    initial begin
        logic [4:0]  ra [2];
        logic        wfire;
        logic [31:0] pre [2];
        logic [1:0]  exp_v;
        logic [1:0]  seen_v;
        int          n;

        reset = 1'b0; sel = 1'b0; clear = 1'b0; wr = 1'b0; waddr = 5'd0;
        wdata = 32'h0; wbe = 4'h0; rd_en = 2'b00; raddr = 10'd0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        cyc(); cyc();
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h1);

        // Release reset while requesting reads: none may be served during the clear.
        reset = 1'b1; sel = 1'b1; rd_en = 2'b11; raddr = {5'd3, 5'd9};
        n = 0; seen_v = 2'b00;
        while (busy === 1'b1 && n < 100) begin
            n++;
            cyc();
            seen_v = seen_v | rvalid;
        end
        chk("init_busy_len", 64'(n), 64'd32);
        rd_en = 2'b00;
        cyc();
        chk("busy_rd_dropped", 64'(seen_v | rvalid), 64'h0);
        model_clear();
        for (int a = 0; a < 32; a++) read2("init_rd", 5'(a), 5'(31 - a));

        do_write(5'd5, 32'h1234, 4'hF);
        read2("dual_rd5", 5'd5, 5'd5);
        chk("dual_rd5_const", rdata, {32'h1234, 32'h1234});

        do_write(5'd2, 32'hcdef, 4'hF);
        do_write(5'd2, 32'hbeef00aa, 4'b0001);
        read2("byte_en", 5'd2, 5'd5);
        chk("byte_en_const", 64'(rdata[31:0]), 64'h0000cdaa);

        sel = 1'b0; wr = 1'b1; waddr = 5'd21; wdata = 32'hdeef; wbe = 4'hF;
        rd_en = 2'b11; raddr = {5'd21, 5'd21};
        cyc();
        wr = 1'b0; rd_en = 2'b00;
        chk("gate_rvalid", 64'(rvalid), 64'h0);
        chk("gate_hold", rdata, {exp_rd[1], exp_rd[0]});
        read2("gate_rd", 5'd21, 5'd21);
        chk("gate_const", 64'(rdata[31:0]), 64'h0);

        do_write(5'd0, 32'h2424, 4'hF);
        read2("zero_reg", 5'd0, 5'd0);
        chk("zero_reg_const", rdata, 64'h0);

        do_write(5'd30, 32'h5555, 4'hF);
        sel = 1'b1; wr = 1'b1; waddr = 5'd30; wdata = 32'h1def; wbe = 4'hF;
        rd_en = 2'b01; raddr = {5'd0, 5'd30};
        cyc();
        wr = 1'b0; rd_en = 2'b00;
`ifdef REGFILE_BYPASS_EN
        exp_rd[0] = 32'h1def;
`else
        exp_rd[0] = 32'h5555;
`endif
        model_write(5'd30, 32'h1def, 4'hF);
        chk("bypass_valid", 64'(rvalid), 64'h1);
        chk("bypass_data", rdata, {exp_rd[1], exp_rd[0]});
        read2("bypass_after", 5'd30, 5'd30);

        // Random traffic against the word-array model.
        for (int k = 0; k < 400; k++) begin
            sel   = ($urandom_range(0, 4) != 0);
            wr    = 1'($urandom);
            waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wdata = $urandom;
            wbe   = 4'($urandom);
            rd_en = 2'($urandom);
            ra[0] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            ra[1] = 5'($urandom);
            raddr = {ra[1], ra[0]};
            wfire = sel && wr;
            for (int p = 0; p < 2; p++) pre[p] = ref_rd(ra[p]);
            if (wfire) model_write(waddr, wdata, wbe);
            exp_v = 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (sel && rd_en[p]) begin
                    exp_v[p] = 1'b1;
`ifdef REGFILE_BYPASS_EN
                    exp_rd[p] = ref_rd(ra[p]);
`else
                    exp_rd[p] = pre[p];
`endif
                end
            end
            cyc();
            chk("rand_valid", 64'(rvalid), 64'(exp_v));
            chk("rand_data", rdata, {exp_rd[1], exp_rd[0]});
        end
        wr = 1'b0; rd_en = 2'b00;
        chk("rand_busy", 64'(busy), 64'h0);

        do_write(5'd3, 32'h7777, 4'hF);
        sel = 1'b1; clear = 1'b1; wr = 1'b1; waddr = 5'd3; wdata = 32'hffff; wbe = 4'hF;
        cyc();
        clear = 1'b0; wr = 1'b0;
        count_busy("clear_busy_len");
        model_clear();
        read2("clear_rd3", 5'd3, 5'd17);
        chk("clear_rd3_const", 64'(rdata[31:0]), 64'h0);

        // Read and clear in the same cycle, then reset at ptr 10.
        do_write(5'd7, 32'habc, 4'hF);
        sel = 1'b1; clear = 1'b1; rd_en = 2'b01; raddr = {5'd0, 5'd7};
        cyc();
        clear = 1'b0; rd_en = 2'b00;
        chk("mid_rd_valid", 64'(rvalid), 64'h1);
        chk("mid_rd_data", 64'(rdata[31:0]), 64'habc);
        for (int i = 0; i < 9; i++) cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_rdata", rdata, 64'h0);
        chk("mid_rst_rvalid", 64'(rvalid), 64'h0);
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        cyc(); cyc();
        reset = 1'b1;
        count_busy("restart_busy_len");
        model_clear();
        read2("restart_rd", 5'd7, 5'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
